// File: rtl/scramble_ctrl_if.sv
// rtl/scramble_ctrl_if.sv - handshake and RAM2B port bundle for the scramble sequencer
interface scramble_ctrl_if #(
  parameter int ADDR_SIZE = 5
);

  // upstream sample handshake (sample data goes straight into RAM write port A)
  logic                 i_in_valid;
  logic                 o_in_ready;

  // downstream pair handshake (pair data comes straight out of RAM read ports A/B)
  logic                 i_out_ready;
  logic                 o_out_valid;
  logic                 o_out_last;
  logic                 o_frame_done;

  // RAM2B write ports
  logic                 o_write_en_A;
  logic [ADDR_SIZE-1:0] o_write_addr_A;
  logic                 o_write_en_B;
  logic [ADDR_SIZE-1:0] o_write_addr_B;

  // RAM2B read ports
  logic                 o_read_en_A;
  logic                 o_read_en_B;
  logic [ADDR_SIZE-1:0] o_read_addr_A;
  logic [ADDR_SIZE-1:0] o_read_addr_B;

  // controller side
  modport master (
    input  i_in_valid,
    input  i_out_ready,
    output o_in_ready,
    output o_out_valid,
    output o_out_last,
    output o_frame_done,
    output o_write_en_A,
    output o_write_addr_A,
    output o_write_en_B,
    output o_write_addr_B,
    output o_read_en_A,
    output o_read_en_B,
    output o_read_addr_A,
    output o_read_addr_B
  );

  // stream source / sink side
  modport slave (
    output i_in_valid,
    output i_out_ready,
    input  o_in_ready,
    input  o_out_valid,
    input  o_out_last,
    input  o_frame_done,
    input  o_write_en_A,
    input  o_write_addr_A,
    input  o_write_en_B,
    input  o_write_addr_B,
    input  o_read_en_A,
    input  o_read_en_B,
    input  o_read_addr_A,
    input  o_read_addr_B
  );

endinterface

// File: rtl/scramble_ctrl.sv
// rtl/scramble_ctrl.sv - fill/drain address sequencer for the bit-reversal scramble RAM
module scramble_ctrl #(
  parameter int MEM_SIZE  = 32,
  parameter int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  scramble_ctrl_if.master bus
);

  // pair counter needs one bit less than the address; keep at least one bit for MEM_SIZE=2
  localparam int                    PAIR_W    = (ADDR_SIZE > 1) ? ADDR_SIZE - 1 : 1;
  localparam logic [ADDR_SIZE-1:0]  WR_LAST   = ADDR_SIZE'(MEM_SIZE - 1);
  localparam logic [PAIR_W-1:0]     PAIR_LAST = PAIR_W'(MEM_SIZE / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_SIZE-1:0] wr_cnt;
  logic [ADDR_SIZE-1:0] wr_cnt_nxt;
  logic [PAIR_W-1:0]    pair_cnt;
  logic [PAIR_W-1:0]    pair_cnt_nxt;

  logic                 pair_last;
  logic [ADDR_SIZE-1:0] even_addr;
  logic [ADDR_SIZE-1:0] rev_addr_a;
  logic [ADDR_SIZE-1:0] rev_addr_b;

  // final pair of the frame; only meaningful while draining
  assign pair_last = (pair_cnt == PAIR_LAST);

  // state and counters; reset abandons any partial frame but leaves RAM untouched
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      pair_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wr_cnt   <= wr_cnt_nxt;
      pair_cnt <= pair_cnt_nxt;
    end
  end

  // next-state: fill linearly, then drain butterfly pairs, then a one-cycle done marker
  always_comb begin
    state_nxt    = state;
    wr_cnt_nxt   = wr_cnt;
    pair_cnt_nxt = pair_cnt;
    case (state)
      IDLE: begin
        state_nxt = FILL;
      end
      FILL: begin
        // ready is constantly high in FILL, so valid alone is an accept
        if (bus.i_in_valid) begin
          if (wr_cnt == WR_LAST) begin
            wr_cnt_nxt = '0;
            state_nxt  = DRAIN;
          end else begin
            wr_cnt_nxt = wr_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        // valid is constantly high in DRAIN, so ready alone is an accept
        if (bus.i_out_ready) begin
          if (pair_last) begin
            pair_cnt_nxt = '0;
            state_nxt    = DONE;
          end else begin
            pair_cnt_nxt = pair_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = FILL;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // pair addresses: A is bitrev of the even index, B is its partner in the upper half
  always_comb begin
    even_addr  = ADDR_SIZE'({pair_cnt, 1'b0});
    rev_addr_a = '0;
    for (int i = 0; i < ADDR_SIZE; i++) begin
      rev_addr_a[i] = even_addr[ADDR_SIZE-1-i];
    end
    rev_addr_b                = rev_addr_a;
    rev_addr_b[ADDR_SIZE-1]   = 1'b1;
  end

  // output decode from registered state; the only input path is write enable during FILL
  always_comb begin
    bus.o_in_ready     = 1'b0;
    bus.o_out_valid    = 1'b0;
    bus.o_out_last     = 1'b0;
    bus.o_frame_done   = 1'b0;
    bus.o_write_en_A   = 1'b0;
    bus.o_write_addr_A = '0;
    bus.o_write_en_B   = 1'b0;
    bus.o_write_addr_B = '0;
    bus.o_read_en_A    = 1'b0;
    bus.o_read_en_B    = 1'b0;
    bus.o_read_addr_A  = '0;
    bus.o_read_addr_B  = '0;
    case (state)
      FILL: begin
        bus.o_in_ready     = 1'b1;
        bus.o_write_en_A   = bus.i_in_valid;
        bus.o_write_addr_A = wr_cnt;
      end
      DRAIN: begin
        // RAM reads are asynchronous, so the pair is valid in the address cycle
        bus.o_out_valid   = 1'b1;
        bus.o_read_en_A   = 1'b1;
        bus.o_read_en_B   = 1'b1;
        bus.o_read_addr_A = rev_addr_a;
        bus.o_read_addr_B = rev_addr_b;
        bus.o_out_last    = pair_last;
      end
      DONE: begin
        bus.o_frame_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_scramble_ctrl.sv
// tb/tb_scramble_ctrl.sv - scoreboard bench for scramble_ctrl at MEM_SIZE 8 and 32
module tb_scramble_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  scramble_ctrl_if #(.ADDR_SIZE(3)) bus8 ();
  scramble_ctrl_if #(.ADDR_SIZE(5)) bus32 ();

  scramble_ctrl #(.MEM_SIZE(8),  .ADDR_SIZE(3)) u_dut8  (.i_CLK(clk), .i_RST(rst_n), .bus(bus8));
  scramble_ctrl #(.MEM_SIZE(32), .ADDR_SIZE(5)) u_dut32 (.i_CLK(clk), .i_RST(rst_n), .bus(bus32));

  typedef struct {
    int a;
    int b;
    int last;
  } pair_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    wr_q[$];
  pair_t rd_q[$];

  // expected pairs for an 8-sample frame, and landmark pairs for 32
  int exp8_a [4] = '{0, 2, 1, 3};
  int exp8_b [4] = '{4, 6, 5, 7};
  int exp32_a[4] = '{0, 8, 4, 15};
  int exp32_b[4] = '{16, 24, 20, 31};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int bitrev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (v & (1 << i)) r = r | (1 << (w - 1 - i));
    return r;
  endfunction

  task automatic quiet8(input string tag);
    check({tag, "_in_ready"},   bus8.o_in_ready,     0);
    check({tag, "_out_valid"},  bus8.o_out_valid,    0);
    check({tag, "_out_last"},   bus8.o_out_last,     0);
    check({tag, "_frame_done"}, bus8.o_frame_done,   0);
    check({tag, "_wr_en_a"},    bus8.o_write_en_A,   0);
    check({tag, "_wr_addr_a"},  bus8.o_write_addr_A, 0);
    check({tag, "_wr_en_b"},    bus8.o_write_en_B,   0);
    check({tag, "_wr_addr_b"},  bus8.o_write_addr_B, 0);
    check({tag, "_rd_en_a"},    bus8.o_read_en_A,    0);
    check({tag, "_rd_en_b"},    bus8.o_read_en_B,    0);
    check({tag, "_rd_addr_a"},  bus8.o_read_addr_A,  0);
    check({tag, "_rd_addr_b"},  bus8.o_read_addr_B,  0);
  endtask

  // stream 8 samples; toggle=1 drives valid 1,0,1,0,...
  task automatic fill8(input bit toggle);
    int acc = 0;
    int cyc = 0;
    while (acc < 8 && cyc < 64) begin
      @(negedge clk);
      bus8.i_out_ready = 1'b1;
      bus8.i_in_valid  = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (cyc == 0) check("fill_ready_first", bus8.o_in_ready, 1);
      check("fill_wr_en",      bus8.o_write_en_A, bus8.i_in_valid);
      check("fill_wr_en_b",    bus8.o_write_en_B, 0);
      check("fill_no_read",    bus8.o_out_valid,  0);
      check("fill_no_done",    bus8.o_frame_done, 0);
      if (!bus8.i_in_valid) check("fill_hold_addr", bus8.o_write_addr_A, acc);
      if (bus8.i_in_valid && bus8.o_in_ready) begin
        wr_q.push_back(acc);
        acc++;
      end
      if (bus8.o_write_en_A) begin
        if (wr_q.size() > 0) check("fill_wr_addr", bus8.o_write_addr_A, wr_q.pop_front());
        else check("fill_unexpected_wr", 1, 0);
      end
      cyc++;
    end
    if (acc < 8) check("fill_timeout", acc, 8);
    for (int k = 0; k < 4; k++) rd_q.push_back('{exp8_a[k], exp8_b[k], (k == 3)});
  endtask

  // drain 4 pairs, holding ready low for stall_n cycles on pair stall_idx
  task automatic drain8(input int stall_idx, input int stall_n);
    int idx   = 0;
    int cyc   = 0;
    int stall = stall_n;
    bit rdy;
    while (rd_q.size() > 0 && cyc < 64) begin
      @(negedge clk);
      bus8.i_in_valid = 1'b1;
      rdy = !(idx == stall_idx && stall > 0);
      if (!rdy) stall--;
      bus8.i_out_ready = rdy;
      #1;
      if (cyc == 0) check("drain_start", bus8.o_out_valid, 1);
      check("drain_in_ready", bus8.o_in_ready,     0);
      check("drain_wr_en",    bus8.o_write_en_A,   0);
      check("drain_wr_addr",  bus8.o_write_addr_A, 0);
      check("drain_wr_en_b",  bus8.o_write_en_B,   0);
      if (bus8.o_out_valid) begin
        check("drain_rd_addr_a", bus8.o_read_addr_A, rd_q[0].a);
        check("drain_rd_addr_b", bus8.o_read_addr_B, rd_q[0].b);
        check("drain_rd_en_a",   bus8.o_read_en_A,   1);
        check("drain_rd_en_b",   bus8.o_read_en_B,   1);
        check("drain_last",      bus8.o_out_last,    rd_q[0].last);
        if (rdy) begin
          void'(rd_q.pop_front());
          idx++;
        end
      end else begin
        check("drain_valid", 0, 1);
      end
      cyc++;
    end
    if (rd_q.size() > 0) begin
      check("drain_timeout", rd_q.size(), 0);
      rd_q.delete();
    end
    @(negedge clk);
    bus8.i_in_valid  = 1'b0;
    bus8.i_out_ready = 1'b0;
    #1;
    check("done_pulse",     bus8.o_frame_done, 1);
    check("done_out_valid", bus8.o_out_valid,  0);
    check("done_rd_en",     bus8.o_read_en_A,  0);
    check("done_wr_en",     bus8.o_write_en_A, 0);
    check("done_in_ready",  bus8.o_in_ready,   0);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus8.i_in_valid   = 1'b0;
    bus8.i_out_ready  = 1'b0;
    bus32.i_in_valid  = 1'b0;
    bus32.i_out_ready = 1'b0;
    @(negedge clk);
    #1;
    quiet8("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    quiet8("idle0");

    // basic frame, then a second frame back to back
    fill8(0);
    drain8(-1, 0);
    fill8(0);
    drain8(-1, 0);

    // gappy input
    fill8(1);
    drain8(-1, 0);

    // downstream stall on the second pair
    fill8(0);
    drain8(1, 3);

    // reset mid-fill after 5 samples
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus8.i_in_valid = 1'b1;
      #1;
      check("partial_wr_addr", bus8.o_write_addr_A, i);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    quiet8("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    quiet8("idle_after_rst");
    fill8(0);
    drain8(-1, 0);

    // 32-sample frame on the larger instance
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus32.i_in_valid = 1'b1;
      #1;
      check("fill32_wr_en",   bus32.o_write_en_A,   1);
      check("fill32_wr_addr", bus32.o_write_addr_A, i);
    end
    for (int k = 0; k < 16; k++) begin
      rd_q.push_back('{bitrev(2 * k, 5), bitrev(2 * k, 5) | 16, (k == 15)});
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus32.i_in_valid  = 1'b0;
      bus32.i_out_ready = 1'b1;
      #1;
      check("drain32_valid",  bus32.o_out_valid,   1);
      check("drain32_addr_a", bus32.o_read_addr_A, rd_q[0].a);
      check("drain32_addr_b", bus32.o_read_addr_B, rd_q[0].b);
      check("drain32_last",   bus32.o_out_last,    rd_q[0].last);
      if (k < 3) begin
        check("drain32_land_a", bus32.o_read_addr_A, exp32_a[k]);
        check("drain32_land_b", bus32.o_read_addr_B, exp32_b[k]);
      end
      if (k == 15) begin
        check("drain32_final_a", bus32.o_read_addr_A, exp32_a[3]);
        check("drain32_final_b", bus32.o_read_addr_B, exp32_b[3]);
      end
      void'(rd_q.pop_front());
    end
    @(negedge clk);
    bus32.i_out_ready = 1'b0;
    #1;
    check("done32_pulse", bus32.o_frame_done, 1);
    check("done32_valid", bus32.o_out_valid,  0);
    @(negedge clk);
    #1;
    check("done32_cleared", bus32.o_frame_done, 0);
    check("refill32_ready", bus32.o_in_ready,   1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
